// File: rtl/writeback_unit_pkg.sv
// Shared constants and types for the writeback unit and its load-result queue.
package writeback_unit_pkg;

  localparam logic        ENABLE           = 1'b1;
  localparam logic        DISABLE          = 1'b0;
  localparam int unsigned WB_DEPTH_DEFAULT = 4;
  localparam int unsigned RD_W             = 5;
  localparam int unsigned DATA_W           = 32;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ALU,
    SEL_QUEUE
  } wb_sel_e;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Register 0 is hardwired; writes to it are dropped.
  function automatic logic rd_live(input logic [RD_W-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Load-result FIFO: circular buffer with occupancy count, flush, and a
// per-entry rd/valid view used for pending-write queries.
module wb_fifo
  import writeback_unit_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_flush,
  input  logic [RD_W-1:0]       i_wr_rd,
  input  logic [DATA_W-1:0]     i_wr_data,
  output logic [RD_W-1:0]       o_head_rd,
  output logic [DATA_W-1:0]     o_head_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH*RD_W-1:0] o_entry_rd,
  output logic [DEPTH-1:0]      o_entry_valid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  wb_entry_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full & ~i_flush;
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

  assign o_head_rd   = r_mem[r_rd_ptr].rd;
  assign o_head_data = r_mem[r_rd_ptr].data;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= '{rd: i_wr_rd, data: i_wr_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    o_entry_rd    = '0;
    o_entry_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      o_entry_rd[i*RD_W +: RD_W] = r_mem[i].rd;
      o_entry_valid[i]           = ({1'b0, AW'(i) - r_rd_ptr}) < r_count;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback: ALU results take priority, load results are queued
// in wb_fifo, and the chosen write is registered onto the register-file port.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int unsigned WB_DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic        flush,
  input  logic [4:0]  query_rd,
  output logic        query_busy,
  output logic        reg_we,
  output logic [4:0]  dstreg_num,
  output logic [31:0] dstreg_data
);

  logic [RD_W-1:0]          w_head_rd;
  logic [DATA_W-1:0]        w_head_data;
  logic                     w_full;
  logic                     w_empty;
  logic [WB_DEPTH*RD_W-1:0] w_entry_rd;
  logic [WB_DEPTH-1:0]      w_entry_valid;
  logic                     w_push;
  logic                     w_pop;
  wb_sel_e                  w_sel;
  logic [RD_W-1:0]          w_wr_rd;
  logic [DATA_W-1:0]        w_wr_data;
  logic                     w_queue_hit;

  logic                     r_we;
  logic [RD_W-1:0]          r_num;
  logic [DATA_W-1:0]        r_data;

  assign ld_ready = ~w_full & ~flush;
  assign w_push   = ld_valid & ld_ready & rd_live(ld_rd);
  assign w_pop    = (w_sel == SEL_QUEUE);

  wb_fifo #(
    .DEPTH(WB_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_flush      (flush),
    .i_wr_rd      (ld_rd),
    .i_wr_data    (ld_data),
    .o_head_rd    (w_head_rd),
    .o_head_data  (w_head_data),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_entry_rd   (w_entry_rd),
    .o_entry_valid(w_entry_valid)
  );

  // Empty is the registered state, so a load pushed this cycle cannot pop until the next.
  always_comb begin
    w_sel     = SEL_NONE;
    w_wr_rd   = r_num;
    w_wr_data = r_data;
    if (alu_valid && rd_live(alu_rd)) begin
      w_sel     = SEL_ALU;
      w_wr_rd   = alu_rd;
      w_wr_data = alu_data;
    end else if (!w_empty && !flush) begin
      w_sel     = SEL_QUEUE;
      w_wr_rd   = w_head_rd;
      w_wr_data = w_head_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we   <= DISABLE;
      r_num  <= '0;
      r_data <= '0;
    end else if (w_sel != SEL_NONE) begin
      r_we   <= ENABLE;
      r_num  <= w_wr_rd;
      r_data <= w_wr_data;
    end else begin
      r_we   <= DISABLE;
    end
  end

  always_comb begin
    w_queue_hit = 1'b0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      if (w_entry_valid[i] && (w_entry_rd[i*RD_W +: RD_W] == query_rd)) begin
        w_queue_hit = 1'b1;
      end
    end
  end

  assign query_busy  = rd_live(query_rd) &&
                       (w_queue_hit || ((r_we == ENABLE) && (r_num == query_rd)));
  assign reg_we      = r_we;
  assign dstreg_num  = r_num;
  assign dstreg_data = r_data;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed and randomized bench for writeback_unit against a queue-based
// reference of the writeback rules.
module tb_writeback_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        flush;
  logic [4:0]  query_rd;
  logic        query_busy;
  logic        reg_we;
  logic [4:0]  dstreg_num;
  logic [31:0] dstreg_data;

  writeback_unit #(.WB_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .flush      (flush),
    .query_rd   (query_rd),
    .query_busy (query_busy),
    .reg_we     (reg_we),
    .dstreg_num (dstreg_num),
    .dstreg_data(dstreg_data)
  );

  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Reference state: pending loads in arrival order plus the expected write port.
  logic [36:0] mq[$];
  logic        m_we;
  logic [4:0]  m_num;
  logic [31:0] m_data;
  logic        m_accepted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
    flush     = 1'b0; query_rd = '0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_we = 1'b0; m_num = '0; m_data = '0;
  endtask

  // Called shortly after a rising edge with inputs already applied.
  task automatic step();
    logic        exp_ready, exp_busy, hit;
    logic [36:0] e;
    exp_ready = (mq.size() < DEPTH) && !flush;
    hit = 1'b0;
    foreach (mq[k]) if (mq[k][36:32] == query_rd) hit = 1'b1;
    exp_busy = (query_rd != 0) && (hit || (m_we && m_num == query_rd));
    #2;
    chk("ld_ready", {31'd0, ld_ready}, {31'd0, exp_ready});
    chk("query_busy", {31'd0, query_busy}, {31'd0, exp_busy});
    @(posedge clk);
    m_accepted = ld_valid && exp_ready;
    if (alu_valid && alu_rd != 0) begin
      m_we = 1'b1; m_num = alu_rd; m_data = alu_data;
    end else if (!flush && mq.size() > 0) begin
      e = mq.pop_front();
      m_we = 1'b1; m_num = e[36:32]; m_data = e[31:0];
    end else begin
      m_we = 1'b0;
    end
    if (flush) mq.delete();
    else if (m_accepted && ld_rd != 0) mq.push_back({ld_rd, ld_data});
    #1;
    chk("reg_we", {31'd0, reg_we}, {31'd0, m_we});
    chk("dstreg_num", {27'd0, dstreg_num}, {27'd0, m_num});
    chk("dstreg_data", dstreg_data, m_data);
  endtask

  initial begin
    int unsigned idx;
    idle();
    model_reset();
    rst = 1'b0;
    #3;
    chk("rst_we", {31'd0, reg_we}, 32'd0);
    chk("rst_num", {27'd0, dstreg_num}, 32'd0);
    chk("rst_data", dstreg_data, 32'd0);
    chk("rst_ready", {31'd0, ld_ready}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    // ALU only
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    step();
    chk("alu_we", {31'd0, reg_we}, 32'd1);
    chk("alu_num", {27'd0, dstreg_num}, 32'd5);
    chk("alu_data", dstreg_data, 32'h1234);
    idle(); step();

    // ALU and load collide
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAA;
    ld_valid  = 1'b1; ld_rd  = 5'd7; ld_data  = 32'hBB;
    step();
    chk("col1_num", {27'd0, dstreg_num}, 32'd3);
    chk("col1_data", dstreg_data, 32'hAA);
    idle(); step();
    chk("col2_we", {31'd0, reg_we}, 32'd1);
    chk("col2_num", {27'd0, dstreg_num}, 32'd7);
    chk("col2_data", dstreg_data, 32'hBB);
    step();
    chk("col3_we", {31'd0, reg_we}, 32'd0);

    // Fill under ALU pressure, then drain
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'(c);
      ld_valid = (idx < 5); ld_rd = 5'(10 + idx); ld_data = 32'hD000 + idx;
      step();
      if (m_accepted) idx++;
    end
    #1 chk("fill_ready_low", {31'd0, ld_ready}, 32'd0);
    for (int c = 0; c < 8; c++) begin
      alu_valid = 1'b0; alu_rd = '0;
      ld_valid = (idx < 5); ld_rd = 5'(10 + idx); ld_data = 32'hD000 + idx;
      step();
      if (m_accepted) idx++;
    end
    idle(); step();

    // Zero register cases
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
    step();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hBEEF;
    step();
    chk("zero_we", {31'd0, reg_we}, 32'd1);
    chk("zero_num", {27'd0, dstreg_num}, 32'd9);
    idle(); step();
    chk("zero_nowrite", {31'd0, reg_we}, 32'd0);

    // Flush and query
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h44; step();
    ld_rd = 5'd6; ld_data = 32'h66; step();
    ld_valid = 1'b0; query_rd = 5'd6;
    #1 chk("q_busy", {31'd0, query_busy}, 32'd1);
    step();
    alu_valid = 1'b0; flush = 1'b1; step();
    flush = 1'b0;
    #1 chk("q_clear", {31'd0, query_busy}, 32'd0);
    step();
    chk("flush_nowrite", {31'd0, reg_we}, 32'd0);
    idle(); step();

    // Reset mid-operation
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h20 + c;
      ld_valid = 1'b1; ld_rd = 5'(20 + c); ld_data = 32'h300 + c;
      step();
    end
    idle();
    rst = 1'b0;
    #1;
    chk("mrst_we", {31'd0, reg_we}, 32'd0);
    chk("mrst_num", {27'd0, dstreg_num}, 32'd0);
    chk("mrst_data", dstreg_data, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    #1 chk("mrst_ready", {31'd0, ld_ready}, 32'd1);
    for (int c = 0; c < 4; c++) step();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      alu_valid = ($urandom % 3) == 0;
      alu_rd    = (($urandom % 4) == 0) ? 5'd0 : 5'($urandom);
      alu_data  = $urandom;
      ld_valid  = ($urandom % 2) == 0;
      ld_rd     = (($urandom % 6) == 0) ? 5'd0 : 5'($urandom);
      ld_data   = $urandom;
      flush     = ($urandom % 20) == 0;
      query_rd  = 5'($urandom);
      step();
    end
    idle();
    for (int c = 0; c < 8; c++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter: WB_DEPTH, default 4, number of load-result queue entries (power of two).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 alu_valid  input  1  ALU result present this cycle, always accepted.
REQ-005 alu_rd  input  5  ALU destination register number.
REQ-006 alu_data  input  32  ALU result.
REQ-007 ld_valid  input  1  load result offered.
REQ-008 ld_ready  output  1  queue can accept load result this cycle.
REQ-009 ld_rd  input  5  load destination register number.
REQ-010 ld_data  input  32  load result.
REQ-011 flush  input  1  discard all queued load results.
REQ-012 query_rd  input  5  register number checked for pending write.
REQ-013 query_busy  output  1  query_rd has a write queued or in the output stage.
REQ-014 reg_we  output  1  register-file write enable (`ENABLE when writing).
REQ-015 dstreg_num  output  5  register-file write address.
REQ-016 dstreg_data  output  32  register-file write data.

Function
REQ-017 Load transfer SHALL occur when ld_valid and ld_ready are both 1 on a rising edge.
REQ-018 ld_ready SHALL be combinational: 1 iff queue count < WB_DEPTH and flush is 0; independent of ld_valid.
REQ-019 Accepted loads with ld_rd = 0 SHALL be consumed (handshake completes) but not enqueued.
REQ-020 Per cycle, the selected write SHALL be: ALU if alu_valid and alu_rd != 0; else queue head if queue non-empty; else none.
REQ-021 ALU results with alu_rd = 0 SHALL produce no write and SHALL not block a queue pop that cycle.
REQ-022 Selected write SHALL appear on reg_we/dstreg_num/dstreg_data registered, exactly 1 cycle after selection; reg_we = 0 otherwise, dstreg_num/data hold last value.
REQ-023 Queue SHALL be FIFO; pointers log2(WB_DEPTH) bits, wrap modulo WB_DEPTH; count 0..WB_DEPTH.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; push into an empty queue SHALL not be popped the same cycle (earliest write 2 cycles after handshake).
REQ-025 Full queue (count = WB_DEPTH): ld_ready = 0; pop that cycle frees a slot visible next cycle only.
REQ-026 flush = 1 SHALL empty the queue next edge, block push that cycle and suppress any pop selection; an ALU write that cycle SHALL proceed.
REQ-027 query_busy SHALL be combinational: 1 iff query_rd != 0 and matches any valid queue entry or the output stage with reg_we = 1.
REQ-028 ALU starvation of the queue is permitted; no ordering between ALU and queued writes to the same rd is enforced (hazard logic uses query_busy).

Reset
REQ-029 rst = 0 SHALL asynchronously set reg_we = 0, dstreg_num = 0, dstreg_data = 0, count = 0, pointers = 0; queue entry data need not be cleared.
REQ-030 Reset mid-operation SHALL discard all queued loads; ld_ready = 1 in the first cycle after release.

Structure
REQ-031 `ENABLE/`DISABLE and the WB_DEPTH default SHALL come from the shared define.vh.
REQ-032 Queue SHALL be one sub-module wb_fifo (push, pop, flush, head, full, empty, per-entry rd/valid vector for query match); selection and output stage in writeback_unit.

Verification
REQ-033 ALU only: alu_valid=1, alu_rd=5, alu_data=32'h1234 -> next cycle reg_we=1, dstreg_num=5, dstreg_data=32'h1234.
REQ-034 Collision: ALU rd=3 data=AA and load rd=7 data=BB same cycle -> cycle+1 write r3=AA, cycle+2 write r7=BB.
REQ-035 Fill: ALU busy with rd!=0 every cycle, 5 loads offered -> ld_ready drops after 4th; stop ALU -> 4 loads written in order, then 5th accepted and written.
REQ-036 Zero register: alu_rd=0 with queue holding r9 -> r9 written next cycle; ld_rd=0 accepted, no write, count unchanged.
REQ-037 Flush/query: queue r4,r6; query_rd=6 -> query_busy=1; assert flush -> following cycle query_busy=0, no writes of r4/r6.
REQ-038 Reset: rst low with 3 queued loads and reg_we=1 -> outputs 0 immediately, no queued writes after release, ld_ready=1.
